sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, where DEPTH = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter AF_LEVEL, default 1020, fill level at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 4, fill level at or below which almost_empty asserts; legal range 0..DEPTH-1.
REQ-005 SHALL have parameter MARKER_EN, default 1, which enables trailer insertion.
REQ-006 SHALL have parameter MARKER_WORD, default 16'hFAF1, the frame-marker value.
REQ-007 SHALL have parameter TRAILER_WORD, default 16'hF1FA, the word inserted after a marker.
REQ-008 SHALL have port clk, input, 1 bit, the single clock; all logic uses the rising edge.
REQ-009 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-010 SHALL have port wr_en, input, 1 bit, a write request.
REQ-011 SHALL have port wr_data, input, WIDTH bits, the write word.
REQ-012 SHALL have port rd_en, input, 1 bit, a read request.
REQ-013 SHALL have port clr_err, input, 1 bit, which clears the sticky error flags.
REQ-014 SHALL have port rd_data, output, WIDTH bits, registered read word.
REQ-015 SHALL have port rd_valid, output, 1 bit, a one-cycle pulse marking a new word on rd_data.
REQ-016 SHALL have ports fifo_full and fifo_empty, outputs, 1 bit each, status flags.
REQ-017 SHALL have ports almost_full and almost_empty, outputs, 1 bit each, threshold flags.
REQ-018 SHALL have port fill_count, output, ADDR_WIDTH+1 bits, the number of stored words (0..DEPTH).
REQ-019 SHALL have ports overflow and underflow, outputs, 1 bit each, sticky error flags.

Function
REQ-020 SHALL keep the write and read pointers ADDR_WIDTH+1 bits wide, wrapping modulo 2*DEPTH.
- fifo_empty = pointers equal.
- fifo_full = MSBs differ and lower ADDR_WIDTH bits equal.
REQ-021 SHALL compute fill_count = wr_ptr - rd_ptr (mod 2^(ADDR_WIDTH+1)), and derive almost_full (fill_count >= AF_LEVEL) and almost_empty (fill_count <= AE_LEVEL) combinationally from the pointers.
REQ-022 SHALL accept a write when wr_en=1 and fifo_full=0; mem[wr_ptr] is stored and wr_ptr increments at that edge.
REQ-023 SHALL reject wr_en=1 while fifo_full=1: no storage, no pointer change, overflow set.
REQ-024 SHALL use a state machine with states NORMAL and TRAILER; reset enters NORMAL.
REQ-025 In NORMAL, SHALL accept a read when rd_en=1 and fifo_empty=0: rd_data <= mem[rd_ptr], rd_valid=1 next cycle, rd_ptr increments.
- Read latency is one clock.
REQ-026 In NORMAL, rd_en=1 with fifo_empty=1 SHALL set underflow, leave rd_valid=0 and hold rd_data.
REQ-027 Full and empty SHALL be evaluated on registered pointers; there is no write-to-read bypass.
- Simultaneous read and write while empty: write accepted, read rejected.
- Simultaneous read and write while full: read accepted, write rejected.
- Otherwise both accepted and fill_count is unchanged.
REQ-028 When MARKER_EN=1 and an accepted read returns MARKER_WORD, the state SHALL go to TRAILER.
REQ-029 In TRAILER, for exactly one cycle:
- rd_data <= TRAILER_WORD with rd_valid=1.
- rd_ptr does not move and rd_en is ignored (no pop, no underflow).
- The state then returns to NORMAL.
- Writes proceed normally throughout.
REQ-030 Back-to-back markers SHALL each be followed by one trailer (M,T,M,T).
REQ-031 With MARKER_EN=0, the state SHALL never leave NORMAL.
REQ-032 rd_data SHALL hold its value whenever no word is delivered; rd_valid is 0 in those cycles.
REQ-033 overflow and underflow SHALL stay set until clr_err=1.
- If an error event and clr_err occur in the same cycle, the flag is set (set wins).

Reset
REQ-034 With rst=1 at a rising edge, the block SHALL set:
- wr_ptr=0, rd_ptr=0, state NORMAL;
- rd_data=0, rd_valid=0, overflow=0, underflow=0;
- hence fifo_empty=1, fifo_full=0, fill_count=0, almost_empty=1, almost_full=0.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 Reset asserted mid-operation, including in TRAILER, SHALL discard all stored data and any pending trailer.

Verification
REQ-037 Write 1024 words 0..1023 then 1 more (defaults) -> fifo_full=1, fill_count=1024, overflow=1, the 1025th word is dropped; reading 1024 words returns 0..1023 in order with fifo_empty=1 at the end.
REQ-038 Write 0x1111, MARKER_WORD 0xFAF1, 0x2222; hold rd_en=1 -> rd_data sequence 0x1111, 0xFAF1, 0xF1FA, 0x2222 on consecutive rd_valid cycles, and fill_count stays 1 during the trailer cycle.
REQ-039 Simultaneous wr_en and rd_en on an empty FIFO -> no rd_valid, fill_count=1; on a full FIFO -> one word read, fill_count=1023, overflow=1.
REQ-040 rd_en on an empty FIFO -> underflow=1; then clr_err=1 with rd_en=1 on an empty FIFO in the same cycle -> underflow remains 1; clr_err alone -> 0.
REQ-041 Fill to 1020 -> almost_full rises on the edge of the 1020th write; drain to 4 -> almost_empty rises; pointers wrap past 2048 writes with correct data.
REQ-042 Assert rst in the TRAILER cycle -> next cycle rd_valid=0, rd_data=0, fifo_empty=1, and no trailer is emitted.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Bus bundle for sync_fifo_param: write/read handshakes, error clear,
// read data and the status/threshold flags.
interface sync_fifo_param_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic                  rd_en;
    logic                  clr_err;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side of the FIFO.
    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, fifo_full, fifo_empty, almost_full,
               almost_empty, fill_count, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, fifo_full, fifo_empty, almost_full,
               almost_empty, fill_count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with registered read port, sticky overflow/underflow
// flags, threshold flags and optional trailer insertion after a frame marker.
//
// state   | meaning
// --------+-----------------------------------------------------------
// NORMAL  | regular pops on rd_en
// TRAILER | one cycle emitting TRAILER_WORD; rd_ptr frozen, rd_en ignored
module sync_fifo_param #(
    parameter int               WIDTH        = 16,
    parameter int               ADDR_WIDTH   = 10,
    parameter int               AF_LEVEL     = 1020,
    parameter int               AE_LEVEL     = 4,
    parameter int               MARKER_EN    = 1,
    parameter logic [WIDTH-1:0] MARKER_WORD  = 16'hFAF1,
    parameter logic [WIDTH-1:0] TRAILER_WORD = 16'hF1FA
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_LVL  = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL  = AE_LEVEL[ADDR_WIDTH:0];

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        TRAILER = 1'b1
    } state_t;

    logic [WIDTH-1:0]    mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                full, empty, wr_accept, rd_reject;
    logic [ADDR_WIDTH:0] fill;
    logic [WIDTH-1:0]    head_word;

    // Status flags come from registered pointers only, so a word written this
    // cycle cannot be read until the next one.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        fill  = wr_ptr_q - rd_ptr_q;
        head_word = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    // Next-state, pointer, read-port and sticky-error logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_reject   = 1'b0;
        wr_accept   = bus.wr_en && !full;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            NORMAL: begin
                if (bus.rd_en) begin
                    if (!empty) begin
                        rd_data_d  = head_word;
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + PTR_ONE;
                        if ((MARKER_EN != 0) && (head_word == MARKER_WORD)) begin
                            state_d = TRAILER;
                        end
                    end else begin
                        rd_reject = 1'b1;
                    end
                end
            end
            TRAILER: begin
                rd_data_d  = TRAILER_WORD;
                rd_valid_d = 1'b1;
                state_d    = NORMAL;
            end
            default: state_d = NORMAL;
        endcase

        // A new error event beats a simultaneous clear.
        overflow_d  = (bus.wr_en && full) || (overflow_q && !bus.clr_err);
        underflow_d = rd_reject || (underflow_q && !bus.clr_err);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NORMAL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.fill_count   = fill;
    assign bus.almost_full  = (fill >= AF_LVL);
    assign bus.almost_empty = (fill <= AE_LVL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param with default parameters. Stimulus pushes the
// expected read words into a queue; a monitor pops and compares on rd_valid.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(16), .ADDR_WIDTH(10)) bus ();

    sync_fifo_param dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.clr_err = c;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every delivered word must match the next expectation.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got rd_data=%h with rd_valid, required no word", bus.rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.rd_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h, required %h", bus.rd_data, mon_exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;

        // Reset state
        check("rst_empty", 32'(bus.fifo_empty), 1);
        check("rst_full", 32'(bus.fifo_full), 0);
        check("rst_fill", 32'(bus.fill_count), 0);
        check("rst_ae", 32'(bus.almost_empty), 1);
        check("rst_af", 32'(bus.almost_full), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_udf", 32'(bus.underflow), 0);

        // Fill to full with 0..1023, watching thresholds
        for (int i = 0; i < 1024; i++) begin
            step(1, 16'(i), 0, 0);
            if (i == 3)    check("ae_fill4", 32'(bus.almost_empty), 1);
            if (i == 4)    check("ae_fill5", 32'(bus.almost_empty), 0);
            if (i == 1018) check("af_fill1019", 32'(bus.almost_full), 0);
            if (i == 1019) check("af_fill1020", 32'(bus.almost_full), 1);
        end
        check("full_flag", 32'(bus.fifo_full), 1);
        check("full_fill", 32'(bus.fill_count), 1024);
        check("full_no_ovf", 32'(bus.overflow), 0);
        step(1, 16'hDEAD, 0, 0);
        check("ovf_set", 32'(bus.overflow), 1);
        check("ovf_fill", 32'(bus.fill_count), 1024);
        step(0, 0, 0, 1);
        check("ovf_clr", 32'(bus.overflow), 0);

        // Drain in order
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(16'(i));
            step(0, 0, 1, 0);
            if (i == 3)    check("af_fill1020_drain", 32'(bus.almost_full), 1);
            if (i == 4)    check("af_fill1019_drain", 32'(bus.almost_full), 0);
            if (i == 1018) check("ae_fill5_drain", 32'(bus.almost_empty), 0);
            if (i == 1019) check("ae_fill4_drain", 32'(bus.almost_empty), 1);
        end
        check("drain_empty", 32'(bus.fifo_empty), 1);
        check("drain_fill", 32'(bus.fill_count), 0);
        step(0, 0, 0, 0);

        // Second round crosses the 2048-write pointer wrap
        for (int i = 0; i < 1024; i++) step(1, 16'h8000 + 16'(i), 0, 0);
        check("wrap_full", 32'(bus.fifo_full), 1);
        check("wrap_fill", 32'(bus.fill_count), 1024);

        // Simultaneous read+write while full
        exp_q.push_back(16'h8000);
        step(1, 16'hBEEF, 1, 0);
        check("rw_full_fill", 32'(bus.fill_count), 1023);
        check("rw_full_ovf", 32'(bus.overflow), 1);
        check("rw_full_notfull", 32'(bus.fifo_full), 0);
        for (int i = 1; i < 1024; i++) begin
            exp_q.push_back(16'h8000 + 16'(i));
            step(0, 0, 1, 0);
        end
        check("wrap_drain_empty", 32'(bus.fifo_empty), 1);

        // Simultaneous read+write while empty
        step(1, 16'h1234, 1, 0);
        check("rw_empty_no_valid", 32'(bus.rd_valid), 0);
        check("rw_empty_fill", 32'(bus.fill_count), 1);
        exp_q.push_back(16'h1234);
        step(0, 0, 1, 0);
        check("rw_empty_drained", 32'(bus.fifo_empty), 1);
        step(0, 0, 0, 1);
        check("clr_ovf", 32'(bus.overflow), 0);
        check("clr_udf", 32'(bus.underflow), 0);

        // Underflow, clear-vs-set priority
        step(0, 0, 1, 0);
        check("udf_set", 32'(bus.underflow), 1);
        check("udf_no_valid", 32'(bus.rd_valid), 0);
        check("udf_hold_data", 32'(bus.rd_data), 32'h1234);
        step(0, 0, 1, 1);
        check("udf_set_wins", 32'(bus.underflow), 1);
        step(0, 0, 0, 1);
        check("udf_cleared", 32'(bus.underflow), 0);

        // Marker followed by trailer
        step(1, 16'h1111, 0, 0);
        step(1, 16'hFAF1, 0, 0);
        step(1, 16'h2222, 0, 0);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'hFAF1);
        exp_q.push_back(16'hF1FA);
        exp_q.push_back(16'h2222);
        step(0, 0, 1, 0);
        check("mk_fill_a", 32'(bus.fill_count), 2);
        step(0, 0, 1, 0);
        check("mk_fill_b", 32'(bus.fill_count), 1);
        step(0, 0, 1, 0);
        check("mk_fill_trailer", 32'(bus.fill_count), 1);
        step(0, 0, 1, 0);
        check("mk_fill_end", 32'(bus.fill_count), 0);
        step(0, 0, 0, 0);

        // Back-to-back markers; rd_en in final trailer cycle is ignored
        step(1, 16'hFAF1, 0, 0);
        step(1, 16'hFAF1, 0, 0);
        exp_q.push_back(16'hFAF1);
        exp_q.push_back(16'hF1FA);
        exp_q.push_back(16'hFAF1);
        exp_q.push_back(16'hF1FA);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        check("b2b_no_udf", 32'(bus.underflow), 0);
        check("b2b_empty", 32'(bus.fifo_empty), 1);
        step(0, 0, 0, 0);

        // Reset during the trailer cycle
        step(1, 16'hFAF1, 0, 0);
        step(1, 16'h3333, 0, 0);
        exp_q.push_back(16'hFAF1);
        step(0, 0, 1, 0);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        check("rst_tr_valid", 32'(bus.rd_valid), 0);
        check("rst_tr_data", 32'(bus.rd_data), 0);
        check("rst_tr_empty", 32'(bus.fifo_empty), 1);
        check("rst_tr_fill", 32'(bus.fill_count), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
